// File: rtl/dispatch_pkg.sv
// Shared types and constants for the instruction dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dispatch_pkg;

    localparam int NUM_CORES = 4;
    localparam int CORE_W    = $clog2(NUM_CORES);
    localparam int INSN_W    = 32;

    localparam logic [INSN_W-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } dispatch_state_t;

    // First ready core at or after ptr, wrapping; returns ptr when none is ready.
    function automatic logic [CORE_W-1:0] rr_pick(input logic [NUM_CORES-1:0] ready,
                                                  input logic [CORE_W-1:0]    ptr);
        logic [CORE_W-1:0] idx;
        logic [CORE_W-1:0] pick;
        logic              found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = ptr + CORE_W'(k);
            if (!found && ready[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/instruction_dispatcher_if.sv
// Producer handshake and per-core instruction buses of the dispatcher.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the producer side, core_ready per core.
interface instruction_dispatcher_if;
    import dispatch_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [INSN_W-1:0]    in_instruction;
    logic [NUM_CORES-1:0] core_ready;
    logic [INSN_W-1:0]    instructions_core0;
    logic [INSN_W-1:0]    instructions_core1;
    logic [INSN_W-1:0]    instructions_core2;
    logic [INSN_W-1:0]    instructions_core3;
    logic [NUM_CORES-1:0] core_issue;

    modport master (
        output in_valid, in_instruction, core_ready,
        input  in_ready, instructions_core0, instructions_core1,
               instructions_core2, instructions_core3, core_issue
    );

    modport slave (
        input  in_valid, in_instruction, core_ready,
        output in_ready, instructions_core0, instructions_core1,
               instructions_core2, instructions_core3, core_issue
    );

endinterface

// File: rtl/dispatch_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers and an occupancy count.
// Latency: head valid the cycle after the push edge; no bypass.
// Backpressure: push ignored when full, pop ignored when empty.
module dispatch_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// Buffers a 32-bit instruction stream and issues it round-robin to four cores; optional
// per-core issue counters under DISPATCH_STATS_EN. Latency: pushed at edge t, issued at t+1 earliest.
// Backpressure: in_ready low when FIFO full or not in RUN; cores gate issue via core_ready.
module instruction_dispatcher
    import dispatch_pkg::*;
#(
    parameter int                DEPTH    = 8,
    parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
`ifdef DISPATCH_STATS_EN
    ,
    parameter int                CNT_W    = 16
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    instruction_dispatcher_if.slave      bus,
    input  logic                         halt_req,
    output logic                         halted,
    output logic [$clog2(DEPTH):0]       fifo_level
`ifdef DISPATCH_STATS_EN
    ,
    output logic [CNT_W-1:0]             issue_count_core0,
    output logic [CNT_W-1:0]             issue_count_core1,
    output logic [CNT_W-1:0]             issue_count_core2,
    output logic [CNT_W-1:0]             issue_count_core3
`endif
);

    dispatch_state_t      state_q, state_d;
    logic [CORE_W-1:0]    rr_ptr_q;
    logic [CORE_W-1:0]    sel;
    logic                 in_ready_c;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [INSN_W-1:0]    head;
    logic [NUM_CORES-1:0] issue_d;
    logic [NUM_CORES-1:0] issue_q;
    logic [INSN_W-1:0]    bus_q [NUM_CORES];

    dispatch_fifo #(.DEPTH(DEPTH), .W(INSN_W)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (bus.in_instruction),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        sel        = rr_pick(bus.core_ready, rr_ptr_q);
        // Full test uses registered occupancy only: no pass-through when full.
        in_ready_c = (state_q == RUN) && !fifo_full;
        push       = bus.in_valid && in_ready_c;
        pop        = (state_q != HALTED) && !fifo_empty && (|bus.core_ready);
        issue_d    = '0;
        if (pop) issue_d[sel] = 1'b1;

        case (state_q)
            RUN:     if (halt_req) state_d = DRAIN;
            DRAIN: begin
                if (!halt_req)               state_d = RUN;
                else if (fifo_empty && !pop) state_d = HALTED;
            end
            HALTED:  if (!halt_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            rr_ptr_q <= '0;
            issue_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) bus_q[i] <= NOP_INSN;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            if (pop) rr_ptr_q <= sel + CORE_W'(1);
            for (int i = 0; i < NUM_CORES; i++)
                bus_q[i] <= issue_d[i] ? head : NOP_INSN;
        end
    end

    assign bus.in_ready           = in_ready_c;
    assign bus.core_issue         = issue_q;
    assign bus.instructions_core0 = bus_q[0];
    assign bus.instructions_core1 = bus_q[1];
    assign bus.instructions_core2 = bus_q[2];
    assign bus.instructions_core3 = bus_q[3];
    assign halted                 = (state_q == HALTED);

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CORES];

    // Counts follow the issue bit being registered; saturate rather than wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
        end else if (state_q != HALTED) begin
            for (int i = 0; i < NUM_CORES; i++)
                if (issue_d[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    assign issue_count_core0 = cnt_q[0];
    assign issue_count_core1 = cnt_q[1];
    assign issue_count_core2 = cnt_q[2];
    assign issue_count_core3 = cnt_q[3];
`endif

endmodule
